irq_timer_bank: RTL and testbench

Parametrised periodic interrupt generator for the PicoRV32 simulation harness: it replaces the hard-wired free-running-counter IRQ taps with NCH independently programmable timer channels. Each channel has a period, a pulse or level mode, an optional one-shot mode, and a pending/overrun status. The CPU (or the bench) configures channels through a small register port. The block drives the core's `irq` vector and takes its `eoi` vector back.

---
 rtl/irq_timer_bank.sv | 192 +++++++++++++++++++
 tb/tb_irq_timer_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_timer_bank.sv
// irq_timer_bank: NCH programmable periodic interrupt channels behind a small register port.
// Optional IRQ_TIMER_LEGACY_EN: channels 0/1 reset running with the legacy irq[4]/irq[5] cadence.
module irq_timer_bank #(
    parameter int NCH      = 4,
    parameter int CNT_W    = 16,
    parameter int IRQ_W    = 32,
    parameter int IRQ_BASE = 4,
    parameter int ADDR_W   = $clog2(NCH) + 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              cfg_write,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic              cfg_rvalid,
    output logic [31:0]       cfg_rdata,
    input  logic [IRQ_W-1:0]  eoi,
    output logic [IRQ_W-1:0]  irq
);

    if (NCH < 1 || NCH > 8) begin : g_chk_nch
        $error("irq_timer_bank: NCH must be in 1..8");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_chk_cnt
        $error("irq_timer_bank: CNT_W must be in 1..32");
    end
    if (IRQ_BASE + NCH > IRQ_W) begin : g_chk_irq
        $error("irq_timer_bank: IRQ_BASE + NCH exceeds IRQ_W");
    end
`ifdef IRQ_TIMER_LEGACY_EN
    if (NCH < 2 || CNT_W < 16) begin : g_chk_legacy
        $error("irq_timer_bank: legacy reset needs NCH >= 2 and CNT_W >= 16");
    end
`endif

    logic [31:0]    w_ch_idx;
    logic [1:0]     w_reg;
    logic           w_wr;
    logic           w_rd;
    logic [NCH-1:0] w_irq_vec;
    logic [NCH-1:0] w_sel_vec;
    logic [31:0]    w_rword [NCH];
    logic [31:0]    w_rd_mux;
    logic           r_rvalid;
    logic [31:0]    r_rdata;
    logic           w_unused;

    assign w_ch_idx  = 32'(cfg_addr) >> 2;
    assign w_reg     = cfg_addr[1:0];
    assign w_wr      = cfg_valid & cfg_write;
    assign w_rd      = cfg_valid & ~cfg_write;
    assign cfg_ready = 1'b1;
    assign w_unused  = ^{cfg_wdata, eoi, w_ch_idx};

    for (genvar n = 0; n < NCH; n++) begin : g_ch
`ifdef IRQ_TIMER_LEGACY_EN
        localparam logic             RST_EN  = (n < 2) ? 1'b1 : 1'b0;
        localparam logic [CNT_W-1:0] RST_PER = (n == 0) ? CNT_W'(32'd8191) :
                                               (n == 1) ? CNT_W'(32'd65535) : {CNT_W{1'b1}};
`else
        localparam logic             RST_EN  = 1'b0;
        localparam logic [CNT_W-1:0] RST_PER = {CNT_W{1'b1}};
`endif
        logic             r_en, r_level, r_oneshot, r_pend, r_irq;
        logic [CNT_W-1:0] r_period, r_count;
        logic [7:0]       r_ovr;
        logic             w_sel, w_wr_ctrl, w_wr_per, w_fire, w_clr, w_lvl_off;
        logic             w_en_nxt, w_pend_nxt, w_irq_nxt;
        logic [7:0]       w_ovr_nxt;
        logic [CNT_W-1:0] w_count_nxt;

        assign w_sel     = (w_ch_idx == 32'(n));
        assign w_wr_ctrl = w_wr & w_sel & (w_reg == 2'd0);
        assign w_wr_per  = w_wr & w_sel & (w_reg == 2'd1);
        assign w_clr     = eoi[IRQ_BASE + n] | (w_wr & w_sel & (w_reg == 2'd3) & cfg_wdata[0]);
        assign w_lvl_off = w_wr_ctrl & r_level & ~cfg_wdata[1];
        // A PERIOD write on the compare edge restarts the count and swallows that fire.
        assign w_fire    = r_en & (r_count == r_period) & ~w_wr_per;

        // Next-state for enable, count and the level-mode pending/overrun status.
        always_comb begin
            w_en_nxt    = r_en;
            w_pend_nxt  = r_pend;
            w_ovr_nxt   = r_ovr;
            w_count_nxt = r_count;
            w_irq_nxt   = 1'b0;

            if (w_wr_ctrl) begin
                w_en_nxt = cfg_wdata[0];
            end else if (w_fire && r_oneshot) begin
                w_en_nxt = 1'b0;
            end else begin
                w_en_nxt = r_en;
            end

            if (w_wr_per || !r_en || !w_en_nxt || w_fire) begin
                w_count_nxt = {CNT_W{1'b0}};
            end else begin
                w_count_nxt = r_count + CNT_W'(1'b1);
            end

            if (w_lvl_off) begin
                w_pend_nxt = 1'b0;
                w_ovr_nxt  = 8'd0;
            end else if (w_fire && r_level) begin
                w_pend_nxt = 1'b1;
                if (w_clr) begin
                    w_ovr_nxt = 8'd0;
                end else if (r_pend && r_ovr != 8'hFF) begin
                    w_ovr_nxt = r_ovr + 8'd1;
                end else begin
                    w_ovr_nxt = r_ovr;
                end
            end else if (w_clr) begin
                w_pend_nxt = 1'b0;
                w_ovr_nxt  = 8'd0;
            end else begin
                w_pend_nxt = r_pend;
                w_ovr_nxt  = r_ovr;
            end

            w_irq_nxt = r_level ? w_pend_nxt : w_fire;
        end

        // Channel state registers.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                r_en      <= RST_EN;
                r_level   <= 1'b0;
                r_oneshot <= 1'b0;
                r_period  <= RST_PER;
                r_count   <= {CNT_W{1'b0}};
                r_pend    <= 1'b0;
                r_ovr     <= 8'd0;
                r_irq     <= 1'b0;
            end else begin
                r_en    <= w_en_nxt;
                r_count <= w_count_nxt;
                r_pend  <= w_pend_nxt;
                r_ovr   <= w_ovr_nxt;
                r_irq   <= w_irq_nxt;
                if (w_wr_ctrl) begin
                    r_level   <= cfg_wdata[1];
                    r_oneshot <= cfg_wdata[2];
                end
                if (w_wr_per) begin
                    r_period <= cfg_wdata[CNT_W-1:0];
                end
            end
        end

        // Register view of this channel for the read port (pre-edge values).
        always_comb begin
            case (w_reg)
                2'd0:    w_rword[n] = {29'd0, r_oneshot, r_level, r_en};
                2'd1:    w_rword[n] = 32'(r_period);
                2'd2:    w_rword[n] = 32'(r_count);
                2'd3:    w_rword[n] = {16'd0, r_ovr, 7'd0, r_pend};
                default: w_rword[n] = 32'd0;
            endcase
        end

        assign w_irq_vec[n] = r_irq;
        assign w_sel_vec[n] = w_sel;
    end

    // Channel select for reads; out-of-range channels leave the result at 0.
    always_comb begin
        w_rd_mux = 32'd0;
        for (int i = 0; i < NCH; i++) begin
            w_rd_mux = w_rd_mux | (w_sel_vec[i] ? w_rword[i] : 32'd0);
        end
    end

    // Read response register, one cycle after the accepted read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_rvalid <= w_rd;
            r_rdata  <= w_rd ? w_rd_mux : 32'd0;
        end
    end

    assign cfg_rvalid = r_rvalid;
    assign cfg_rdata  = r_rdata;
    assign irq        = IRQ_W'(w_irq_vec) << IRQ_BASE;

endmodule

// File: tb/tb_irq_timer_bank.sv
// Scoreboard bench for irq_timer_bank: directed test-plan scenarios followed by random
// register traffic, all checked against a cycle-level reference model of the channel rules.
module tb_irq_timer_bank;
    localparam int NCH = 4;
    localparam int CNT_W = 16;
    localparam int IRQ_W = 32;
    localparam int BASE = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          cfg_write = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [31:0]   cfg_wdata = 32'd0;
    logic          cfg_rvalid;
    logic [31:0]   cfg_rdata;
    logic [31:0]   eoi = 32'd0;
    logic [31:0]   irq;

    irq_timer_bank #(.NCH(NCH), .CNT_W(CNT_W), .IRQ_W(IRQ_W), .IRQ_BASE(BASE), .ADDR_W(AW)) dut (
        .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_write(cfg_write), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata), .eoi(eoi), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rv;
        logic [31:0] rd;
        logic [31:0] irq;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   rn_v = 1'b0;

    // Reference model: one entry per channel, state in plain integers.
    bit          m_en[NCH], m_lvl[NCH], m_os[NCH], m_pend[NCH];
    int unsigned m_cnt[NCH], m_per[NCH], m_ovr[NCH];

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 1'b0; m_lvl[c] = 1'b0; m_os[c] = 1'b0; m_pend[c] = 1'b0;
            m_cnt[c] = 0; m_ovr[c] = 0; m_per[c] = 32'hFFFF;
        end
`ifdef IRQ_TIMER_LEGACY_EN
        m_en[0] = 1'b1; m_per[0] = 8191;
        m_en[1] = 1'b1; m_per[1] = 65535;
`endif
    endfunction

    function automatic void model_step(input bit rn, input bit v, input bit w,
                                       input logic [AW-1:0] a, input logic [31:0] d,
                                       input logic [31:0] e);
        exp_t        x;
        int unsigned ch, rg;
        bit          sel, wr_per, wr_ctrl, fire, clr, nen;
        x.rv = 1'b0; x.rd = 32'd0; x.irq = 32'd0;
        ch = 32'(a) >> 2;
        rg = 32'(a) & 32'd3;
        if (!rn) begin
            model_reset();
        end else begin
            if (v && !w) begin
                x.rv = 1'b1;
                if (ch < NCH) begin
                    case (rg)
                        0: x.rd = {29'd0, m_os[ch], m_lvl[ch], m_en[ch]};
                        1: x.rd = m_per[ch];
                        2: x.rd = m_cnt[ch];
                        default: x.rd = (m_ovr[ch] << 8) | 32'(m_pend[ch]);
                    endcase
                end
            end
            for (int c = 0; c < NCH; c++) begin
                sel     = v && w && (ch == c);
                wr_per  = sel && rg == 1;
                wr_ctrl = sel && rg == 0;
                fire    = m_en[c] && (m_cnt[c] == m_per[c]) && !wr_per;
                clr     = e[BASE + c] || (sel && rg == 3 && d[0]);
                if (wr_ctrl && m_lvl[c] && !d[1]) begin
                    m_pend[c] = 1'b0; m_ovr[c] = 0;
                end else if (fire && m_lvl[c]) begin
                    if (clr) m_ovr[c] = 0;
                    else if (m_pend[c] && m_ovr[c] < 255) m_ovr[c]++;
                    m_pend[c] = 1'b1;
                end else if (clr) begin
                    m_pend[c] = 1'b0; m_ovr[c] = 0;
                end
                x.irq[BASE + c] = m_lvl[c] ? m_pend[c] : fire;
                nen = wr_ctrl ? d[0] : ((fire && m_os[c]) ? 1'b0 : m_en[c]);
                if (wr_per || !m_en[c] || !nen || fire) m_cnt[c] = 0;
                else m_cnt[c] = (m_cnt[c] + 1) & 32'hFFFF;
                m_en[c] = nen;
                if (wr_ctrl) begin m_lvl[c] = d[1]; m_os[c] = d[2]; end
                if (wr_per) m_per[c] = d & 32'hFFFF;
            end
        end
        q.push_back(x);
    endfunction

    task automatic drive(input bit v, input bit w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [31:0] e);
        @(negedge clk);
        resetn = rn_v; cfg_valid = v; cfg_write = w; cfg_addr = a; cfg_wdata = d; eoi = e;
        model_step(rn_v, v, w, a, d, e);
    endtask

    task automatic wr(input int a, input int d);
        drive(1'b1, 1'b1, AW'(a), 32'(d), 32'd0);
    endtask
    task automatic rd(input int a);
        drive(1'b1, 1'b0, AW'(a), 32'd0, 32'd0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 32'd0, 32'd0);
    endtask

    // Monitor: pops one expectation per edge and compares the DUT outputs after the edge.
    exp_t e_m;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e_m = q.pop_front();
                n_checks++;
                if (cfg_rvalid !== e_m.rv) begin
                    n_errors++;
                    $display("FAIL rvalid @%0t: got %0b expected %0b", $time, cfg_rvalid, e_m.rv);
                end
                n_checks++;
                if (cfg_rdata !== e_m.rd) begin
                    n_errors++;
                    $display("FAIL rdata @%0t: got %h expected %h", $time, cfg_rdata, e_m.rd);
                end
                n_checks++;
                if (irq !== e_m.irq) begin
                    n_errors++;
                    $display("FAIL irq @%0t: got %h expected %h", $time, irq, e_m.irq);
                end
                n_checks++;
                if (cfg_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL ready @%0t: got %b expected 1", $time, cfg_ready);
                end
            end
        end
    end

    initial begin
        int unsigned r;
        logic [AW-1:0] a;
        logic [31:0] d, e;
        int guard;
        model_reset();
        rn_v = 1'b0;
        idle(3);
        rn_v = 1'b1;
        idle(2);
        // CH0 pulse mode, P = 9, COUNT sweep
        wr(1, 9); wr(0, 1);
        for (int i = 0; i < 25; i++) rd(2);
        wr(0, 0);
        // CH1 level mode, P = 3, overrun then eoi
        wr(5, 3); wr(4, 3);
        idle(12);
        rd(7);
        drive(1'b0, 1'b0, '0, 32'd0, 32'h20);
        rd(7);
        wr(4, 0);
        // CH2 level mode, eoi exactly on a fire edge
        wr(9, 4); wr(8, 3);
        guard = 0;
        while (!(m_en[2] && m_cnt[2] == m_per[2]) && guard < 20) begin idle(1); guard++; end
        drive(1'b0, 1'b0, '0, 32'd0, 32'h40);
        rd(11);
        idle(2);
        rd(11);
        wr(8, 0);
        // CH3 one-shot
        wr(13, 5); wr(12, 5);
        idle(20);
        rd(12); rd(14);
        // PERIOD write on the compare cycle, then out-of-range read
        wr(1, 6); wr(0, 1);
        guard = 0;
        while (!(m_en[0] && m_cnt[0] == m_per[0]) && guard < 20) begin idle(1); guard++; end
        wr(1, 6);
        idle(10);
        wr(0, 0);
        rd(31);
        rd(31); rd(2);
        // Random register traffic
        for (int k = 0; k < 2000; k++) begin
            r = $urandom_range(0, 199);
            a = AW'($urandom_range(0, 31));
            d = $urandom;
            if (a[1:0] == 2'd1) d = 32'($urandom_range(0, 9));
            e = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
            rn_v = (r == 0) ? 1'b0 : 1'b1;
            if (r < 60) drive(1'b1, 1'b1, a, d, e);
            else if (r < 120) drive(1'b1, 1'b0, a, d, e);
            else drive(1'b0, 1'b0, '0, 32'd0, e);
        end
        rn_v = 1'b1;
`ifdef IRQ_TIMER_LEGACY_EN
        rn_v = 1'b0; idle(1); rn_v = 1'b1;
        idle(66000);
        rn_v = 1'b0; idle(1); rn_v = 1'b1;
        idle(9000);
`endif
        idle(3);
        @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
